// File: rtl/gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_pkg.sv
// Shared definitions for the preset-to-set storage bank: address sizing,
// default preset fill and the per-bit masked merge used by every word.
package gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_pkg;

    // Each word defaults to all ones, matching the set-type primitive cell.
    localparam logic DEFAULT_SET_FILL = 1'b1;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WRITE,
        OP_SET
    } wr_op_e;

    // A single-word bank still needs a one-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic logic masked_merge(input logic old_bit,
                                          input logic d_bit,
                                          input logic m_bit);
        return (old_bit & ~m_bit) | (d_bit & m_bit);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_if.sv
// Write/read bus of the storage bank; the bank itself is the slave.
interface gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_if
    import gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = addr_width(DEPTH);

    logic             E;
    logic             SETW;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] M;
    logic [AW-1:0]    RA;
    logic             CLRD;
    logic [WIDTH-1:0] Q;
    logic [DEPTH-1:0] DIRTY;

    modport master (
        output E, SETW, WA, D, M, RA, CLRD,
        input  Q, DIRTY
    );

    modport slave (
        input  E, SETW, WA, D, M, RA, CLRD,
        output Q, DIRTY
    );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__regsnq_word.sv
// One storage word with async preset, synchronous set, masked write and a
// dirty flag; exposes its next-state value so the bank can forward reads.
module gf180mcu_fd_sc_mcu9t5v0__regsnq_word
    import gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DEFAULT_SET_FILL}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic             wr_en,
    input  logic             clrd,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] nxt,
    output logic             dirty
);

    logic [WIDTH-1:0] word_q;
    logic             dirty_q;

    always_comb begin
        nxt = word_q;
        if (set_en) begin
            nxt = SET_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                nxt[i] = masked_merge(word_q[i], d[i], m[i]);
            end
        end
    end

    // A hit on this word decides its own dirty bit and so overrides a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= SET_VAL;
            dirty_q <= 1'b0;
        end else begin
            word_q <= nxt;
            if (set_en || wr_en) begin
                dirty_q <= (nxt != SET_VAL);
            end else if (clrd) begin
                dirty_q <= 1'b0;
            end
        end
    end

    assign dirty = dirty_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__regsnq_bank.sv
// WIDTH x DEPTH bank of set-type storage words with masked writes, per-word
// dirty tracking and a registered, write-first read port.
module gf180mcu_fd_sc_mcu9t5v0__regsnq_bank
    import gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DEFAULT_SET_FILL}}
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_if.slave bus
);

    localparam int            AW      = addr_width(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    wr_op_e           op;
    logic             wa_ok;
    logic [WIDTH-1:0] word_nxt [DEPTH];
    logic [DEPTH-1:0] dirty_w;
    logic [WIDTH-1:0] rd_nxt;
    logic [WIDTH-1:0] q_r;

    assign wa_ok = ({1'b0, bus.WA} < DEPTH_W);

    // An all-zero mask is not a write at all, so it must not touch DIRTY.
    always_comb begin
        op = OP_NONE;
        if (wa_ok) begin
            if (bus.SETW) begin
                op = OP_SET;
            end else if (bus.E && (|bus.M)) begin
                op = OP_WRITE;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic sel;
        assign sel = (bus.WA == AW'(g));

        gf180mcu_fd_sc_mcu9t5v0__regsnq_word #(
            .WIDTH   (WIDTH),
            .SET_VAL (SET_VAL)
        ) u_word (
            .clk    (CLK),
            .rst_n  (RN),
            .set_en (sel && (op == OP_SET)),
            .wr_en  (sel && (op == OP_WRITE)),
            .clrd   (bus.CLRD),
            .d      (bus.D),
            .m      (bus.M),
            .nxt    (word_nxt[g]),
            .dirty  (dirty_w[g])
        );
    end

    // Reading next-state values gives write-first forwarding for free;
    // addresses past the last word fall through to SET_VAL.
    always_comb begin
        rd_nxt = SET_VAL;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.RA == AW'(i)) begin
                rd_nxt = word_nxt[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q_r <= SET_VAL;
        end else begin
            q_r <= rd_nxt;
        end
    end

    assign bus.Q     = q_r;
    assign bus.DIRTY = dirty_w;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__regsnq_bank.sv
// Drives a 4-word and a 3-word bank with identical traffic and checks both
// against an array model of the bank every cycle.
module tb_gf180mcu_fd_sc_mcu9t5v0__regsnq_bank;

    logic       clk = 1'b0;
    logic       rn  = 1'b1;
    logic       e, setw, clrd;
    logic [1:0] wa, ra;
    logic [7:0] d, m;
    logic       check_en = 1'b0;
    int         total = 0;
    int         bad   = 0;

    logic [7:0] mmem   [2][4];
    logic [3:0] mdirty [2];
    logic [7:0] mq     [2];
    int         mdepth [2] = '{4, 3};

    gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    gf180mcu_fd_sc_mcu9t5v0__regsnq_bank_if #(.WIDTH(8), .DEPTH(3)) ifb ();

    assign ifa.E = e;    assign ifa.SETW = setw; assign ifa.WA = wa;
    assign ifa.D = d;    assign ifa.M = m;       assign ifa.RA = ra;
    assign ifa.CLRD = clrd;
    assign ifb.E = e;    assign ifb.SETW = setw; assign ifb.WA = wa;
    assign ifb.D = d;    assign ifb.M = m;       assign ifb.RA = ra;
    assign ifb.CLRD = clrd;

    gf180mcu_fd_sc_mcu9t5v0__regsnq_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
        .CLK (clk),
        .RN  (rn),
        .bus (ifa)
    );

    gf180mcu_fd_sc_mcu9t5v0__regsnq_bank #(.WIDTH(8), .DEPTH(3)) dut_b (
        .CLK (clk),
        .RN  (rn),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    // Model of the bank: plain arrays updated from the operation rules.
    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mmem[k][i] = 8'hFF;
            mdirty[k] = 4'b0000;
            mq[k]     = 8'hFF;
        end
    endtask

    task automatic modelStep();
        logic       written;
        logic [7:0] nv;
        for (int k = 0; k < 2; k++) begin
            written = 1'b0;
            nv      = 8'hFF;
            if (int'(wa) < mdepth[k]) begin
                if (setw) begin
                    nv = 8'hFF;
                    written = 1'b1;
                end else if (e && m != 8'h00) begin
                    nv = (mmem[k][wa] & ~m) | (d & m);
                    written = 1'b1;
                end
            end
            if (clrd) mdirty[k] = 4'b0000;
            if (written) begin
                mmem[k][wa]   = nv;
                mdirty[k][wa] = (nv != 8'hFF);
            end
            mq[k] = (int'(ra) < mdepth[k]) ? mmem[k][ra] : 8'hFF;
        end
    endtask

    always @(posedge clk) begin
        if (rn) modelStep();
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("a_q",     ifa.Q,                mq[0]);
            checkOutput("a_dirty", {4'b0, ifa.DIRTY},    {4'b0, mdirty[0]});
            checkOutput("b_q",     ifb.Q,                mq[1]);
            checkOutput("b_dirty", {5'b0, ifb.DIRTY},    {5'b0, mdirty[1][2:0]});
        end
    end

    task automatic applyStimulus(input logic ie, input logic is, input logic ic,
                                 input logic [1:0] iwa, input logic [7:0] id,
                                 input logic [7:0] im, input logic [1:0] ira);
        @(negedge clk);
        e = ie; setw = is; clrd = ic; wa = iwa; d = id; m = im; ra = ira;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_a_q"},     ifa.Q,             8'hFF);
        checkOutput({tag, "_a_dirty"}, {4'b0, ifa.DIRTY}, 8'h00);
        checkOutput({tag, "_b_q"},     ifb.Q,             8'hFF);
        checkOutput({tag, "_b_dirty"}, {5'b0, ifb.DIRTY}, 8'h00);
    endtask

    // Reset lands between edges so the check shows it acts without a clock.
    task automatic resetPulse();
        @(negedge clk);
        #2;
        rn = 1'b0;
        modelReset();
        #1;
        checkResetState("midrst");
        @(negedge clk);
        #2;
        rn = 1'b1;
    endtask

    initial begin
        e = 0; setw = 0; clrd = 0; wa = 0; d = 0; m = 0; ra = 0;
        modelReset();
        #1 rn = 1'b0;
        #1;
        checkResetState("rst");
        @(negedge clk);
        #2 rn = 1'b1;
        check_en = 1'b1;

        applyStimulus(1, 0, 0, 2'd2, 8'h5A, 8'h0F, 2'd0);
        applyStimulus(0, 0, 0, 2'd0, 8'h00, 8'h00, 2'd2);
        checkOutput("mask_q",      ifa.Q,             8'hFA);
        checkOutput("mask_dirty",  {4'b0, ifa.DIRTY}, 8'h04);

        applyStimulus(1, 0, 0, 2'd1, 8'h00, 8'hFF, 2'd1);
        checkOutput("fwd_q",       ifa.Q,             8'h00);
        checkOutput("fwd_dirty",   {4'b0, ifa.DIRTY}, 8'h06);

        applyStimulus(1, 1, 0, 2'd1, 8'h00, 8'hFF, 2'd1);
        checkOutput("setw_q",      ifa.Q,             8'hFF);
        checkOutput("setw_dirty",  {4'b0, ifa.DIRTY}, 8'h04);

        applyStimulus(1, 0, 1, 2'd3, 8'h00, 8'hFF, 2'd3);
        checkOutput("clrd_a_q",     ifa.Q,             8'h00);
        checkOutput("clrd_a_dirty", {4'b0, ifa.DIRTY}, 8'h08);
        checkOutput("oob_b_q",      ifb.Q,             8'hFF);
        checkOutput("clrd_b_dirty", {5'b0, ifb.DIRTY}, 8'h00);

        applyStimulus(1, 0, 0, 2'd0, 8'h12, 8'hFF, 2'd0);
        applyStimulus(1, 0, 0, 2'd3, 8'h00, 8'hFF, 2'd0);
        checkOutput("oobw_b_q",     ifb.Q,             8'h12);
        checkOutput("oobw_b_dirty", {5'b0, ifb.DIRTY}, 8'h01);

        applyStimulus(1, 0, 0, 2'd3, 8'hFF, 8'hFF, 2'd3);
        checkOutput("wrset_q",      ifa.Q,             8'hFF);
        checkOutput("wrset_dirty",  {4'b0, ifa.DIRTY}, 8'h01);

        applyStimulus(1, 0, 0, 2'd0, 8'h00, 8'h00, 2'd0);
        checkOutput("m0_q",         ifa.Q,             8'h12);
        checkOutput("m0_dirty",     {4'b0, ifa.DIRTY}, 8'h01);

        resetPulse();

        for (int n = 0; n < 600; n++) begin
            logic [7:0] rm;
            case ($urandom_range(0, 3))
                0:       rm = 8'h00;
                1:       rm = 8'hFF;
                default: rm = 8'($urandom);
            endcase
            applyStimulus(1'($urandom), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0), 2'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                          rm, 2'($urandom));
            if (n == 300) resetPulse();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
